decode_issue_buffer: RTL



---
 rtl/decode_issue_buffer_pkg.sv | 44 ++++
 rtl/decode_issue_buffer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/decode_issue_buffer_pkg.sv
// Shared decode-side types: the decoded instruction bundle and base opcodes.
// Imported by decode, sign extension and the decode/issue buffer.
package decode_issue_buffer_pkg;

    typedef struct packed {
        logic [4:0]  op_code;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
    } dec_instr_t;

    // opcode[6:2] of the RV32I base opcodes
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    function automatic dec_instr_t pack_instr(
        input logic [4:0]  op_code,
        input logic [31:0] imm,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] pc
    );
        dec_instr_t e;
        e.op_code = op_code;
        e.imm     = imm;
        e.rd      = rd;
        e.rs1     = rs1;
        e.rs2     = rs2;
        e.pc      = pc;
        return e;
    endfunction

endpackage

// File: rtl/decode_issue_buffer.sv
// Two-in / two-out circular buffer between decode and issue.
// Slot 0 is always the older instruction on both sides.
module decode_issue_buffer
    import decode_issue_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [1:0]            in_valid,
    output logic                  in_ready,
    input  logic [1:0][4:0]       in_op_code,
    input  logic [1:0][31:0]      in_imm,
    input  logic [1:0][4:0]       in_rd,
    input  logic [1:0][4:0]       in_rs1,
    input  logic [1:0][4:0]       in_rs2,
    input  logic [1:0][31:0]      in_pc,
    output logic [1:0]            out_valid,
    output logic [1:0][4:0]       out_op_code,
    output logic [1:0][31:0]      out_imm,
    output logic [1:0][4:0]       out_rd,
    output logic [1:0][4:0]       out_rs1,
    output logic [1:0][4:0]       out_rs2,
    output logic [1:0][31:0]      out_pc,
    input  logic [1:0]            out_accept,
    output logic [CNT_W-1:0]      count,
    output logic                  protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);

    dec_instr_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;
    dec_instr_t       wr0;
    dec_instr_t       wr1;
    dec_instr_t       rd0;
    dec_instr_t       rd1;
    logic             in_err;
    logic             out_err;
    logic [1:0]       n_in;
    logic [1:0]       n_out;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    // Only registered occupancy gates the producer; a same-cycle dequeue does not help.
    assign in_ready     = (count <= CNT_W'(DEPTH - 2));
    assign out_valid[0] = (count != '0);
    assign out_valid[1] = (count > CNT_W'(1));

    assign in_err  = (in_valid == 2'b10);
    assign out_err = (out_accept == 2'b10) || (|(out_accept & ~out_valid));

    always_comb begin
        n_in = 2'd0;
        if (in_ready && !in_err) begin
            n_in = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
        end
    end

    always_comb begin
        n_out = 2'd0;
        if (!out_err) begin
            n_out = {1'b0, out_accept[0]} + {1'b0, out_accept[1]};
        end
    end

    assign wr0 = pack_instr(in_op_code[0], in_imm[0], in_rd[0],
                            in_rs1[0], in_rs2[0], in_pc[0]);
    assign wr1 = pack_instr(in_op_code[1], in_imm[1], in_rd[1],
                            in_rs1[1], in_rs2[1], in_pc[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_out);
            tail  <= tail + PTR_W'(n_in);
            count <= count + CNT_W'(n_in) - CNT_W'(n_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (in_err || out_err) begin
            protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush) begin
            if (n_in != 2'd0) begin
                mem[tail] <= wr0;
            end
            if (n_in == 2'd2) begin
                mem[tail1] <= wr1;
            end
        end
    end

    assign rd0 = mem[head];
    assign rd1 = mem[head1];

    assign out_op_code = {rd1.op_code, rd0.op_code};
    assign out_imm     = {rd1.imm,     rd0.imm};
    assign out_rd      = {rd1.rd,      rd0.rd};
    assign out_rs1     = {rd1.rs1,     rd0.rs1};
    assign out_rs2     = {rd1.rs2,     rd0.rs2};
    assign out_pc      = {rd1.pc,      rd0.pc};

endmodule
